// File: rtl/fifo_mem_ctrl_if.sv
// FIFO controller bus: requester handshakes, array ports, output stage.
// slave is the controller side; master is the surrounding system.
interface fifo_mem_ctrl_if #(
   parameter int D_WIDTH    = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  req0_valid;
   logic [D_WIDTH-1:0]    req0_data;
   logic                  req0_ready;
   logic                  req1_valid;
   logic [D_WIDTH-1:0]    req1_data;
   logic                  req1_ready;
   logic                  mem_w_en;
   logic [ADDR_WIDTH-1:0] mem_w_addr;
   logic [D_WIDTH-1:0]    mem_w_data;
   logic                  mem_r_en;
   logic [ADDR_WIDTH-1:0] mem_r_addr;
   logic [D_WIDTH-1:0]    mem_r_data;
   logic                  out_valid;
   logic [D_WIDTH-1:0]    out_data;
   logic                  out_ready;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;

   modport slave (
      input  req0_valid, req0_data,
      input  req1_valid, req1_data,
      output req0_ready, req1_ready,
      output mem_w_en, mem_w_addr, mem_w_data,
      output mem_r_en, mem_r_addr,
      input  mem_r_data,
      output out_valid, out_data,
      input  out_ready,
      output count, full, empty
   );

   modport master (
      output req0_valid, req0_data,
      output req1_valid, req1_data,
      input  req0_ready, req1_ready,
      input  mem_w_en, mem_w_addr, mem_w_data,
      input  mem_r_en, mem_r_addr,
      output mem_r_data,
      input  out_valid, out_data,
      output out_ready,
      input  count, full, empty
   );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// FIFO controller: round-robin write arbitration, pointers, occupancy
// and a valid/ready output stage fed by a registered-read array.
module fifo_mem_ctrl #(
   parameter int D_WIDTH    = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   fifo_mem_ctrl_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH:0] wptr;
   logic [ADDR_WIDTH:0] rptr;
   logic [ADDR_WIDTH:0] cnt;
   logic                prio;
   logic                ov_q;
   logic                full_w;
   logic                empty_w;
   logic                g0;
   logic                g1;
   logic                grant;
   logic                r_en;
   logic                both;

   assign cnt     = wptr - rptr;
   assign full_w  = (cnt == FULL_CNT);
   assign empty_w = (wptr == rptr);
   assign both    = bus.req0_valid & bus.req1_valid;

   // Grants and read issue come only from registered state and inputs,
   // and are forced off while reset is held.
   always_comb begin
      g0    = 1'b0;
      g1    = 1'b0;
      r_en  = 1'b0;
      if (rst_n && !full_w && !flush) begin
         g0 = bus.req0_valid & (!bus.req1_valid | !prio);
         g1 = bus.req1_valid & (!bus.req0_valid | prio);
      end
      if (rst_n && !empty_w && !flush)
         r_en = !ov_q | bus.out_ready;
   end

   assign grant = g0 | g1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         prio <= 1'b0;
         ov_q <= 1'b0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         ov_q <= 1'b0;
      end else begin
         if (grant)
            wptr <= wptr + 1'b1;
         if (r_en)
            rptr <= rptr + 1'b1;
         if (r_en)
            ov_q <= 1'b1;
         else if (ov_q && bus.out_ready)
            ov_q <= 1'b0;
         // Turn passes only when both requesters contended.
         if (both && grant)
            prio <= g0;
      end
   end

   assign bus.req0_ready = g0;
   assign bus.req1_ready = g1;
   assign bus.mem_w_en   = grant;
   assign bus.mem_w_addr = wptr[ADDR_WIDTH-1:0];
   assign bus.mem_w_data = g0 ? bus.req0_data :
                           g1 ? bus.req1_data : '0;
   assign bus.mem_r_en   = r_en;
   assign bus.mem_r_addr = rptr[ADDR_WIDTH-1:0];
   assign bus.out_valid  = ov_q;
   assign bus.out_data   = bus.mem_r_data;
   assign bus.count      = cnt;
   assign bus.full       = full_w;
   assign bus.empty      = empty_w;
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Randomized and directed bench for fifo_mem_ctrl against a queue model
// with a behavioural registered-read storage array.
module tb_fifo_mem_ctrl;
   logic clk;
   logic rst_n;
   logic flush;

   fifo_mem_ctrl_if #(.D_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   fifo_mem_ctrl #(
      .D_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (bus.mem_w_en) mem[bus.mem_w_addr] <= bus.mem_w_data;
      if (bus.mem_r_en) bus.mem_r_data <= mem[bus.mem_r_addr];
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue of words held in the array, plus the output slot.
   logic [7:0] q [$];
   bit         m_ov;
   logic [7:0] m_ow;
   bit         m_prio;
   int         wcnt;
   int         rcnt;

   task automatic model_reset();
      q.delete();
      m_ov = 0; m_ow = 0; m_prio = 0; wcnt = 0; rcnt = 0;
   endtask

   task automatic step(input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1,
                       input bit fl, input bit ordy);
      bit e0, e1, iss, mfull, mempty;
      logic [7:0] w;
      bus.req0_valid = v0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_data = d1;
      flush = fl; bus.out_ready = ordy;
      #1;
      mfull  = (q.size() == 16);
      mempty = (q.size() == 0);
      e0 = 0; e1 = 0;
      if (!mfull && !fl) begin
         if (v0 && v1) begin
            e0 = !m_prio; e1 = m_prio;
         end else begin
            e0 = v0; e1 = v1;
         end
      end
      iss = !mempty && !fl && (!m_ov || ordy);
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("mem_w_en", bus.mem_w_en, e0 | e1);
      if (e0 | e1) begin
         chk("mem_w_addr", bus.mem_w_addr, wcnt % 16);
         chk("mem_w_data", bus.mem_w_data, e0 ? d0 : d1);
      end
      chk("mem_r_en", bus.mem_r_en, iss);
      if (iss) chk("mem_r_addr", bus.mem_r_addr, rcnt % 16);
      chk("count", bus.count, q.size());
      chk("full", bus.full, mfull);
      chk("empty", bus.empty, mempty);
      chk("out_valid", bus.out_valid, m_ov);
      if (m_ov) chk("out_data", bus.out_data, m_ow);
      if (fl) begin
         q.delete(); m_ov = 0; wcnt = 0; rcnt = 0;
      end else begin
         if (iss) begin
            w = q.pop_front();
            m_ov = 1; m_ow = w; rcnt++;
         end else if (m_ov && ordy) begin
            m_ov = 0;
         end
         if (e0 | e1) begin
            q.push_back(e0 ? d0 : d1);
            wcnt++;
            if (v0 && v1) m_prio = e0;
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_checks();
      #1;
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_mem_w_en", bus.mem_w_en, 0);
      chk("rst_mem_r_en", bus.mem_r_en, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_empty", bus.empty, 1);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h5a;
      bus.req1_valid = 1'b1; bus.req1_data = 8'ha5;
      bus.out_ready = 1'b1;
      bus.mem_r_data = '0;
      model_reset();
      #2;
      reset_checks();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Two words from req0, consumer always ready.
      step(1, 8'h11, 0, 0, 0, 1);
      step(1, 8'h22, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      chk("t1_empty", bus.empty, 1);

      // Contention alternates.
      for (int n = 0; n < 4; n++)
         step(1, 8'ha0 + 8'(n), 1, 8'hb0 + 8'(n), 0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

      // Fill to full, refuse, then pop and refill.
      for (int n = 0; n < 18; n++) step(1, 8'(8'h40 + n), 0, 0, 0, 0);
      chk("t3_full", bus.full, 1);
      chk("t3_count", bus.count, 16);
      step(1, 8'h77, 0, 0, 0, 1);
      step(1, 8'h78, 0, 0, 0, 0);
      chk("t3_refill_full", bus.full, 1);
      for (int i = 0; i < 22; i++) step(0, 0, 0, 0, 0, 1);

      // Stall with a word pending.
      step(1, 8'h99, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

      // Flush with five words queued and one in the output slot.
      for (int n = 0; n < 6; n++) step(1, 8'(8'hc0 + n), 0, 0, 0, 0);
      chk("t6_count5", bus.count, 5);
      step(0, 0, 1, 8'hee, 1, 0);
      chk("t6_flush_count", bus.count, 0);
      chk("t6_flush_empty", bus.empty, 1);
      chk("t6_flush_ov", bus.out_valid, 0);

      // Random traffic, wrapping pointers many times.
      for (int i = 0; i < 600; i++)
         step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
              ($urandom_range(0, 60) == 0), 1'(i[3] ? $urandom : 1));

      // Asynchronous reset mid-stream.
      for (int n = 0; n < 5; n++) step(1, 8'(n), 1, 8'(n + 16), 0, 0);
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      reset_checks();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++)
         step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
              0, 1'($urandom));
      for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 1);
      chk("end_empty", bus.empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
